mips_state_sequencer: RTL and testbench

- Multi-cycle state sequencer for the MIPS CPU. It sits directly upstream of the combinational control-signal decoder and drives its 3-bit `state` input.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK.
- Stalls on memory waitrequest and on a busy multiply/divide unit.
- Detects the halt condition (JR to address 0), reports `active`, counts retired instructions, and flags stalls that exceed a limit.

---
 rtl/mips_state_sequencer.sv | 128 ++++++++++++
 tb/tb_mips_state_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_state_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK sequencer for the MIPS core.
// Drives the control decoder's state input, tracks retirements, halt and stall watchdog.
module mips_state_sequencer #(
    parameter int STALL_LIMIT = 255,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             func_code,
    input  logic                   waitrequest,
    input  logic                   alu_busy,
    input  logic [31:0]            jump_addr,
    output logic [2:0]             state,
    output logic                   active,
    output logic                   retire,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   bus_error
);

    localparam int SW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_M1 = SW'(STALL_LIMIT - 1);

    typedef enum logic [2:0] {
        S_FETCH      = 3'b000,
        S_DECODE     = 3'b001,
        S_EXECUTE    = 3'b010,
        S_MEM_ACCESS = 3'b011,
        S_WRITE_BACK = 3'b100,
        S_HALT       = 3'b101
    } state_t;

    state_t                 state_q, state_d;
    logic                   active_q, active_d;
    logic                   retire_q, retire_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   bus_err_q, bus_err_d;
    logic [SW-1:0]          stall_cnt_q, stall_cnt_d;

    logic is_load, is_store, is_muldiv, is_jr;
    logic stall, done;

    always_comb begin
        is_load   = ((opcode >= 6'b100000) && (opcode <= 6'b100110)) || (opcode == 6'b001111);
        is_store  = (opcode == 6'b101000) || (opcode == 6'b101001) || (opcode == 6'b101011);
        is_muldiv = (opcode == 6'b000000) && (func_code[5:2] == 4'b0110);
        is_jr     = (opcode == 6'b000000) && (func_code == 6'b001000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            active_q    <= 1'b1;
            retire_q    <= 1'b0;
            count_q     <= '0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            retire_q    <= retire_d;
            count_q     <= count_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // waitrequest=1 means the current memory access was not accepted; the state
    // holds and the access is re-presented on the next cycle.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        done        = 1'b0;
        stall_cnt_d = '0;
        bus_err_d   = bus_err_q;
        unique case (state_q)
            S_FETCH: begin
                if (waitrequest) stall = 1'b1;
                else             state_d = S_DECODE;
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (is_muldiv && alu_busy) stall = 1'b1;
                else                       state_d = S_MEM_ACCESS;
            end
            S_MEM_ACCESS: begin
                if ((is_load || is_store) && waitrequest) begin
                    stall = 1'b1;
                end else if (is_load) begin
                    state_d = S_WRITE_BACK;
                end else if (is_jr && (jump_addr == 32'd0)) begin
                    state_d = S_HALT;
                    done    = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    done    = 1'b1;
                end
            end
            S_WRITE_BACK: begin
                state_d = S_FETCH;
                done    = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Watchdog: the stall that would reach the limit diverts to HALT instead.
        if (stall) begin
            if (stall_cnt_q >= LIMIT_M1) begin
                state_d   = S_HALT;
                bus_err_d = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + SW'(1);
            end
        end

        retire_d = done;
        count_d  = done ? (count_q + COUNT_WIDTH'(1)) : count_q;
        active_d = active_q && (state_d != S_HALT);
    end

    assign state       = state_q;
    assign active      = active_q;
    assign retire      = retire_q;
    assign instr_count = count_q;
    assign bus_error   = bus_err_q;

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Directed bench for mips_state_sequencer: a default instance plus a small one
// (STALL_LIMIT=4, COUNT_WIDTH=4) for the watchdog and counter-wrap cases.
module tb_mips_state_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  func_code;
  logic        waitrequest;
  logic        alu_busy;
  logic [31:0] jump_addr;

  logic [2:0]  state_a, state_b;
  logic        active_a, active_b, retire_a, retire_b, berr_a, berr_b;
  logic [31:0] count_a;
  logic [3:0]  count_b;

  int vectors = 0;
  int miscompares = 0;

  mips_state_sequencer dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
    .waitrequest(waitrequest), .alu_busy(alu_busy), .jump_addr(jump_addr),
    .state(state_a), .active(active_a), .retire(retire_a),
    .instr_count(count_a), .bus_error(berr_a)
  );

  mips_state_sequencer #(.STALL_LIMIT(4), .COUNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
    .waitrequest(waitrequest), .alu_busy(alu_busy), .jump_addr(jump_addr),
    .state(state_b), .active(active_b), .retire(retire_b),
    .instr_count(count_b), .bus_error(berr_b)
  );

  always #5 clk = ~clk;

  // {state, active, retire, bus_error}
  logic [5:0] obs_a, obs_b;
  assign obs_a = {state_a, active_a, retire_a, berr_a};
  assign obs_b = {state_b, active_b, retire_b, berr_b};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    func_code = fn;
  endtask

  task automatic test_reset();
    set_instr(6'b000000, 6'b100001);
    waitrequest = 1'b0; alu_busy = 1'b0; jump_addr = 32'h0;
    do_reset();
    vectors++;
    if (obs_a !== 6'b000_1_0_0 || count_a !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_a: got obs=%b cnt=%0d want obs=000100 cnt=0", obs_a, count_a);
    end
    vectors++;
    if (obs_b !== 6'b000_1_0_0 || count_b !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_b: got obs=%b cnt=%0d want obs=000100 cnt=0", obs_b, count_b);
    end
  endtask

  task automatic test_addu();
    logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic       exp_rt [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    set_instr(6'b000000, 6'b100001);
    waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (obs_a !== {exp_st[i], 1'b1, exp_rt[i], 1'b0}) begin
        miscompares++;
        $display("FAIL addu_edge%0d: got %b want %b", i + 1, obs_a, {exp_st[i], 1'b1, exp_rt[i], 1'b0});
      end
    end
    vectors++;
    if (count_a !== 32'd1) begin
      miscompares++;
      $display("FAIL addu_count: got %0d want 1", count_a);
    end
    step();
    vectors++;
    if (obs_a !== 6'b001_1_0_0 || count_a !== 32'd1) begin
      miscompares++;
      $display("FAIL addu_after: got obs=%b cnt=%0d want obs=001100 cnt=1", obs_a, count_a);
    end
  endtask

  task automatic test_lw();
    logic [2:0] exp_st [8] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    do_reset();
    set_instr(6'b100011, 6'b000000);
    for (int i = 1; i <= 8; i++) begin
      waitrequest = (i >= 4 && i <= 6);
      step();
      vectors++;
      if (obs_a !== {exp_st[i-1], 1'b1, (i == 8), 1'b0}) begin
        miscompares++;
        $display("FAIL lw_edge%0d: got %b want %b", i, obs_a, {exp_st[i-1], 1'b1, (i == 8), 1'b0});
      end
    end
    waitrequest = 1'b0;
    vectors++;
    if (count_a !== 32'd1) begin
      miscompares++;
      $display("FAIL lw_count: got %0d want 1", count_a);
    end
  endtask

  task automatic test_store_and_undef();
    logic [2:0] exp_sw [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd0};
    logic [2:0] exp_ud [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    do_reset();
    set_instr(6'b101011, 6'b000000);
    for (int i = 1; i <= 5; i++) begin
      waitrequest = (i == 4);
      step();
      vectors++;
      if (obs_a !== {exp_sw[i-1], 1'b1, (i == 5), 1'b0}) begin
        miscompares++;
        $display("FAIL sw_edge%0d: got %b want %b", i, obs_a, {exp_sw[i-1], 1'b1, (i == 5), 1'b0});
      end
    end
    // Undefined opcode, waitrequest asserted in MEMORY_ACCESS must be ignored.
    set_instr(6'b111111, 6'b000000);
    for (int i = 1; i <= 4; i++) begin
      waitrequest = (i == 4);
      step();
      vectors++;
      if (obs_a !== {exp_ud[i-1], 1'b1, (i == 4), 1'b0}) begin
        miscompares++;
        $display("FAIL undef_edge%0d: got %b want %b", i, obs_a, {exp_ud[i-1], 1'b1, (i == 4), 1'b0});
      end
    end
    waitrequest = 1'b0;
    vectors++;
    if (count_a !== 32'd2) begin
      miscompares++;
      $display("FAIL sw_undef_count: got %0d want 2", count_a);
    end
  endtask

  task automatic test_mult();
    logic [2:0] exp;
    do_reset();
    set_instr(6'b000000, 6'b011000);
    for (int i = 1; i <= 14; i++) begin
      alu_busy = (i >= 3 && i <= 12);
      waitrequest = (i == 14);
      step();
      exp = (i == 1) ? 3'd1 : (i <= 12) ? 3'd2 : (i == 13) ? 3'd3 : 3'd0;
      vectors++;
      if (obs_a !== {exp, 1'b1, (i == 14), 1'b0}) begin
        miscompares++;
        $display("FAIL mult_edge%0d: got %b want %b", i, obs_a, {exp, 1'b1, (i == 14), 1'b0});
      end
    end
    alu_busy = 1'b0; waitrequest = 1'b0;
    vectors++;
    if (count_a !== 32'd1) begin
      miscompares++;
      $display("FAIL mult_count: got %0d want 1", count_a);
    end
  endtask

  task automatic test_jr();
    do_reset();
    set_instr(6'b000000, 6'b001000);
    jump_addr = 32'h0000_0400;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (obs_a !== 6'b000_1_1_0 || count_a !== 32'd1) begin
      miscompares++;
      $display("FAIL jr_nonzero: got obs=%b cnt=%0d want obs=000110 cnt=1", obs_a, count_a);
    end
    jump_addr = 32'h0;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (obs_a !== 6'b101_0_1_0 || count_a !== 32'd2) begin
      miscompares++;
      $display("FAIL jr_halt: got obs=%b cnt=%0d want obs=101010 cnt=2", obs_a, count_a);
    end
    set_instr(6'b000000, 6'b100001);
    for (int i = 1; i <= 20; i++) begin
      step();
      vectors++;
      if (obs_a !== 6'b101_0_0_0 || count_a !== 32'd2) begin
        miscompares++;
        $display("FAIL halt_hold%0d: got obs=%b cnt=%0d want obs=101000 cnt=2", i, obs_a, count_a);
      end
    end
    do_reset();
    vectors++;
    if (obs_a !== 6'b000_1_0_0 || count_a !== 32'd0) begin
      miscompares++;
      $display("FAIL halt_reset: got obs=%b cnt=%0d want obs=000100 cnt=0", obs_a, count_a);
    end
  endtask

  task automatic test_stall_limit();
    do_reset();
    set_instr(6'b000000, 6'b100001);
    waitrequest = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i <= 3 || i == 4 || i == 8) begin
        vectors++;
        if (obs_b !== ((i <= 3) ? 6'b000_1_0_0 : 6'b101_0_0_1) || count_b !== 4'd0) begin
          miscompares++;
          $display("FAIL stall_b_edge%0d: got obs=%b cnt=%0d want obs=%b cnt=0", i, obs_b, count_b,
                   ((i <= 3) ? 6'b000_1_0_0 : 6'b101_0_0_1));
        end
      end
      if (i == 254 || i == 255) begin
        vectors++;
        if (obs_a !== ((i == 254) ? 6'b000_1_0_0 : 6'b101_0_0_1)) begin
          miscompares++;
          $display("FAIL stall_a_edge%0d: got %b want %b", i, obs_a,
                   ((i == 254) ? 6'b000_1_0_0 : 6'b101_0_0_1));
        end
      end
    end
    waitrequest = 1'b0;
    do_reset();
    vectors++;
    if (obs_b !== 6'b000_1_0_0 || obs_a !== 6'b000_1_0_0) begin
      miscompares++;
      $display("FAIL stall_reset: got a=%b b=%b want 000100", obs_a, obs_b);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_instr(6'b000000, 6'b100001);
    for (int i = 0; i < 4; i++) step();
    set_instr(6'b000000, 6'b011010);
    step(); step();
    alu_busy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (obs_a !== 6'b010_1_0_0 || count_a !== 32'd1) begin
      miscompares++;
      $display("FAIL midstall_pre: got obs=%b cnt=%0d want obs=010100 cnt=1", obs_a, count_a);
    end
    do_reset();
    alu_busy = 1'b0;
    vectors++;
    if (obs_a !== 6'b000_1_0_0 || count_a !== 32'd0 || obs_b !== 6'b000_1_0_0 || count_b !== 4'd0) begin
      miscompares++;
      $display("FAIL midstall_reset: got a=%b/%0d b=%b/%0d want 000100/0", obs_a, count_a, obs_b, count_b);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [3:0] exp_b;
    do_reset();
    set_instr(6'b000000, 6'b100001);
    waitrequest = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      for (int i = 0; i < 4; i++) step();
      exp_b = n[3:0];
      vectors++;
      if (count_b !== exp_b || retire_b !== 1'b1 || berr_b !== 1'b0 || count_a !== 32'(n)) begin
        miscompares++;
        $display("FAIL wrap_n%0d: got b=%0d ret=%b berr=%b a=%0d want b=%0d ret=1 berr=0 a=%0d",
                 n, count_b, retire_b, berr_b, count_a, exp_b, n);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_instr(6'b0, 6'b0);
    waitrequest = 1'b0; alu_busy = 1'b0; jump_addr = 32'h0;
    test_reset();
    test_addu();
    test_lw();
    test_store_and_undef();
    test_mult();
    test_jr();
    test_stall_limit();
    test_reset_mid_stall();
    test_back_to_back_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
